unpadder1: RTL
==============

// Module: unpadder1
// PURPOSE
//  Inverse of the SHA3-512 input padder. Accepts a 520-bit padded frame as a
//  byte stream (65 bytes) and recovers the message and its size code: 0 = empty,
//  1 = 32 B, 2 = 64 B. Flags frames that match no legal padding pattern.
//  Sits on the loopback/verification path after the padder, and on any
//  interface that receives padded frames instead of raw messages.
// PARAMETERS
//  FRAME_BYTES  65    bytes per padded frame; fixed, do not override
//  DSEP         8'h06 domain-separation byte the padder appends
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    synchronous reset, active low
//  in_byte    in   8    frame byte; byte k = frame[519-8k -: 8], k=0 first
//  in_valid   in   1    in_byte valid
//  in_ready   out  1    block accepts in_byte this cycle
//  out_msg    out  512  recovered message, right-aligned (padder input format)
//  byte_num   out  2    0=empty, 1=32 B, 2=64 B, 3=invalid frame
//  err        out  1    frame matches no legal pattern (byte_num=3)
//  out_valid  out  1    out_msg/byte_num/err valid
//  out_ready  in   1    consumer takes the result
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=S_COLLECT, byte count=0, buffer and
//    flags cleared, out_valid=0, err=0, byte_num=0, out_msg=0. in_ready is 1
//    from the first cycle after reset. Reset mid-frame or while holding a
//    result discards all progress.
//  - FSM, two states:
//    S_COLLECT: in_ready=1, out_valid=0. Byte accepted when in_valid&&in_ready;
//      count increments 0..64. Bytes 0..63 shift into the 512-bit buffer
//      (byte 0 ends up in buf[511:504]). Byte 64 goes into a separate 8-bit
//      register. On accepting byte 64: classify, load the outputs, go to S_OUT.
//    S_OUT: in_ready=0, out_valid=1, outputs held stable. On out_valid&&
//      out_ready: out_valid=0, count=0, flags cleared, return to S_COLLECT.
//      in_ready rises the cycle after the handshake.
//  - Latency: out_valid rises on the edge that accepts byte 64, so it is high
//    on the next cycle. Minimum frame period is 66 cycles (65 input + 1 output
//    handshake).
//  - Running flags are updated as each byte is accepted, so classification
//    needs no wide compare at the end:
//    z1  = bytes 1..64 are all 8'h00
//    z33 = bytes 33..64 are all 8'h00
//  - Classification, strict priority:
//    1) byte64==DSEP        -> byte_num=2, out_msg=bytes 0..63
//    2) byte32==DSEP && z33 -> byte_num=1, out_msg={256'h0, bytes 0..31}
//    3) byte0==DSEP && z1   -> byte_num=0, out_msg=0
//    4) otherwise           -> byte_num=3, err=1, out_msg=0
//  - The priority makes the result unambiguous. A 64 B frame always ends in
//    DSEP. A 32 B frame ends in 00 and has DSEP at byte 32. The empty frame
//    has byte32=00.
//  - in_valid while in_ready=0 is ignored; the byte is not consumed.
//  - out_ready while out_valid=0 has no effect.
//  - The count never exceeds 64 and never wraps without a completed output
//    handshake.
// TESTING
//  T1 empty: bytes 06,00x64 -> out_valid on cycle 66; byte_num=0,
//     out_msg=0, err=0.
//  T2 32 B: bytes 00..1F, then 06, then 00x32 -> byte_num=1;
//     out_msg[255:0]=0x000102..1F; out_msg[511:256]=0.
//  T3 64 B with a message full of 06 bytes: 06x64, then 06 -> byte_num=2,
//     out_msg=all 06 (priority 1 beats priority 3).
//  T4 invalid: 32 B frame with byte 40 = 0x01 -> byte_num=3, err=1,
//     out_msg=0.
//  T5 backpressure: in_valid toggled randomly; out_ready held 0 for
//     10 cycles -> in_ready=0 and outputs stable throughout; the next frame
//     is decoded correctly after the handshake.
//  T6 reset: rst_n=0 after 20 bytes, then a full T2 frame -> single correct
//     byte_num=1 result; no result from the partial frame.

Source files
------------

// File: rtl/unpadder1.sv
// unpadder1: recovers message and size code from a 65-byte SHA3-512 padded frame
module unpadder1 #(
  parameter int FRAME_BYTES = 65,
  parameter logic [7:0] DSEP = 8'h06
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] out_msg,
  output logic [1:0]   byte_num,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic {S_COLLECT, S_OUT} state_t;
  state_t state, state_n;
  logic [6:0] cnt;
  logic [511:0] data;
  logic z1, z33, acc, last, zb, p1, p2, p3, done;
  assign acc  = in_valid && in_ready;
  assign last = cnt == 7'(FRAME_BYTES - 1);
  assign done = out_valid && out_ready;
  assign zb   = in_byte == 8'h00;
  assign p1   = in_byte == DSEP;
  assign p2   = data[255:248] == DSEP && z33 && zb;
  assign p3   = data[511:504] == DSEP && z1 && zb;
  always_comb begin
    in_ready  = state == S_COLLECT;
    out_valid = state == S_OUT;
    state_n   = acc && last ? S_OUT : done ? S_COLLECT : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_COLLECT;
      cnt      <= '0;
      data     <= '0;
      z1       <= 1'b1;
      z33      <= 1'b1;
      out_msg  <= '0;
      byte_num <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (acc && !last) begin
        data <= {data[503:0], in_byte};
        cnt  <= cnt + 7'd1;
        if (cnt >= 7'd1) z1 <= z1 & zb;
        if (cnt >= 7'd33) z33 <= z33 & zb;
      end
      if (acc && last) begin
        byte_num <= p1 ? 2'd2 : p2 ? 2'd1 : p3 ? 2'd0 : 2'd3;
        err      <= !(p1 || p2 || p3);
        out_msg  <= p1 ? data : p2 ? {256'h0, data[511:256]} : '0;
      end
      if (done) begin
        cnt <= '0;
        z1  <= 1'b1;
        z33 <= 1'b1;
      end
    end
  end
endmodule
